bus_arb_mo: RTL and testbench

- Parametrised successor to the simulation system bus.
- Connects NrHosts hosts to NrDevices memory-mapped devices (RAM, test utility, future peripherals).
- Adds selectable fixed-priority or round-robin arbitration and up to MaxOutstanding in-order outstanding transactions.
- Unmapped addresses get an internally generated error response instead of hanging.

---
 rtl/bus_arb_mo.sv | 191 +++++++++++++++++++
 tb/tb_bus_arb_mo.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb_mo.sv
// Multi-host to multi-device bus arbiter with fixed-priority or round-robin arbitration,
// an in-order outstanding-response FIFO and internally generated decode-error responses.
`timescale 1ns/1ps
module bus_arb_mo #(
    parameter int NrHosts        = 3,
    parameter int NrDevices      = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int RoundRobin     = 0,
    parameter int MaxOutstanding = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NrHosts-1:0]                        host_req_i,
    output logic [NrHosts-1:0]                        host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]      host_addr_i,
    input  logic [NrHosts-1:0]                        host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]       host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]         host_wdata_i,
    output logic [NrHosts-1:0]                        host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]         host_rdata_o,
    output logic [NrHosts-1:0]                        host_err_o,
    output logic [NrDevices-1:0]                      device_req_o,
    output logic [NrDevices-1:0][AddressWidth-1:0]    device_addr_o,
    output logic [NrDevices-1:0]                      device_we_o,
    output logic [NrDevices-1:0][DataWidth/8-1:0]     device_be_o,
    output logic [NrDevices-1:0][DataWidth-1:0]       device_wdata_o,
    input  logic [NrDevices-1:0]                      device_rvalid_i,
    input  logic [NrDevices-1:0][DataWidth-1:0]       device_rdata_i,
    input  logic [NrDevices-1:0]                      device_err_i,
    input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_base,
    input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_mask
);

    localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);

    typedef struct packed {
        logic [HostW-1:0] host;
        logic [DevW-1:0]  dev;
        logic             err;
    } entry_t;

    entry_t           fifo_mem [MaxOutstanding];
    logic [PtrW-1:0]  wr_ptr_reg;
    logic [PtrW-1:0]  rd_ptr_reg;
    logic [CntW-1:0]  count_reg;
    logic [HostW-1:0] rr_ptr_reg;
    logic             armed_reg;

    logic [HostW-1:0]        arb_base;
    logic                    arb_valid;
    logic [HostW-1:0]        win_idx;
    logic [AddressWidth-1:0] win_addr;
    logic                    dec_hit;
    logic [DevW-1:0]         dec_dev;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [PtrW-1:0]         tail_ptr;
    entry_t                  head;
    entry_t                  tail;
    logic                    same_target;
    logic                    pop;
    logic                    grant;
    logic                    stray_rvalid;

    function automatic logic [HostW-1:0] rr_index(input logic [HostW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NrHosts) s = s - NrHosts;
        return HostW'(s);
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    function automatic logic [HostW-1:0] host_inc(input logic [HostW-1:0] h);
        return (h == HostW'(NrHosts - 1)) ? '0 : h + HostW'(1);
    endfunction

    // Fixed priority is round-robin with the search always starting at host 0.
    assign arb_base = (RoundRobin != 0) ? rr_ptr_reg : '0;

    always_comb begin
        arb_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NrHosts; i++) begin
            if (!arb_valid && host_req_i[rr_index(arb_base, i)]) begin
                arb_valid = 1'b1;
                win_idx   = rr_index(arb_base, i);
            end
        end
    end

    assign win_addr = host_addr_i[win_idx];

    always_comb begin
        dec_hit = 1'b0;
        dec_dev = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!dec_hit &&
                ((win_addr & cfg_device_addr_mask[d]) ==
                 (cfg_device_addr_base[d] & cfg_device_addr_mask[d]))) begin
                dec_hit = 1'b1;
                dec_dev = DevW'(d);
            end
        end
    end

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CntW'(MaxOutstanding));
    assign tail_ptr   = (wr_ptr_reg == '0) ? PtrW'(MaxOutstanding - 1) : wr_ptr_reg - PtrW'(1);
    assign head       = fifo_mem[rd_ptr_reg];
    assign tail       = fifo_mem[tail_ptr];

    // A decode error is its own target, so it never shares the FIFO with device traffic.
    assign same_target = (tail.err == !dec_hit) && (!dec_hit || (tail.dev == dec_dev));

    assign pop   = !fifo_empty && (head.err || device_rvalid_i[head.dev]);
    assign grant = rst_ni && arb_valid && (!fifo_full || pop) && (fifo_empty || same_target);

    always_comb begin
        host_gnt_o = '0;
        if (grant) host_gnt_o[win_idx] = 1'b1;
    end

    for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev
        assign device_req_o[gi]   = grant && dec_hit && (dec_dev == DevW'(gi));
        assign device_addr_o[gi]  = device_req_o[gi] ? win_addr              : '0;
        assign device_we_o[gi]    = device_req_o[gi] && host_we_i[win_idx];
        assign device_be_o[gi]    = device_req_o[gi] ? host_be_i[win_idx]    : '0;
        assign device_wdata_o[gi] = device_req_o[gi] ? host_wdata_i[win_idx] : '0;
    end

    // Responses follow the FIFO head only; an error head answers on its own without a device.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        if (pop) begin
            host_rvalid_o[head.host] = 1'b1;
            if (head.err) begin
                host_err_o[head.host] = 1'b1;
            end else begin
                host_rdata_o[head.host] = device_rdata_i[head.dev];
                host_err_o[head.host]   = device_err_i[head.dev];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) begin
            fifo_mem[wr_ptr_reg] <= '{host: win_idx, dev: dec_dev, err: !dec_hit};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rr_ptr_reg <= '0;
            armed_reg  <= 1'b0;
        end else begin
            if (grant) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                rr_ptr_reg <= host_inc(win_idx);
                armed_reg  <= 1'b1;
            end
            if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (grant && !pop)      count_reg <= count_reg + CntW'(1);
            else if (!grant && pop) count_reg <= count_reg - CntW'(1);
        end
    end

    always_comb begin
        stray_rvalid = 1'b0;
        for (int d = 0; d < NrDevices; d++) begin
            if (device_rvalid_i[d] && !(!fifo_empty && !head.err && (head.dev == DevW'(d))))
                stray_rvalid = 1'b1;
        end
    end

    // Late responses to transactions discarded by reset are expected until the next grant.
    assert property (@(posedge clk_i) disable iff (!rst_ni) armed_reg |-> !stray_rvalid)
        else $error("device rvalid with no matching outstanding transaction");

endmodule

// File: tb/tb_bus_arb_mo.sv
// Scoreboard bench for bus_arb_mo: a fixed-priority instance for most scenarios and a
// round-robin instance with a one-cycle auto-responding RAM for the rotation scenario.
`timescale 1ns/1ps
module tb_bus_arb_mo;
    localparam int NH = 3;
    localparam int ND = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NH-1:0]         req, gnt, rvalid, herr, we;
    logic [NH-1:0][AW-1:0] addr;
    logic [NH-1:0][BW-1:0] be;
    logic [NH-1:0][DW-1:0] wdata, rdata;
    logic [ND-1:0]         dreq, dwe, drvalid, derr;
    logic [ND-1:0][AW-1:0] daddr, cfg_base, cfg_mask;
    logic [ND-1:0][BW-1:0] dbe;
    logic [ND-1:0][DW-1:0] dwdata, drdata;

    logic [NH-1:0]         rr_req, rr_gnt, rr_rvalid, rr_herr;
    logic [NH-1:0][DW-1:0] rr_rdata;
    logic [ND-1:0]         rr_dreq, rr_dwe, rr_drvalid, rr_derr;
    logic [ND-1:0][AW-1:0] rr_daddr;
    logic [ND-1:0][BW-1:0] rr_dbe;
    logic [ND-1:0][DW-1:0] rr_dwdata, rr_drdata;

    bus_arb_mo #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW),
                 .RoundRobin(0), .MaxOutstanding(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(req), .host_gnt_o(gnt), .host_addr_i(addr), .host_we_i(we),
        .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rvalid),
        .host_rdata_o(rdata), .host_err_o(herr),
        .device_req_o(dreq), .device_addr_o(daddr), .device_we_o(dwe),
        .device_be_o(dbe), .device_wdata_o(dwdata), .device_rvalid_i(drvalid),
        .device_rdata_i(drdata), .device_err_i(derr),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    bus_arb_mo #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW),
                 .RoundRobin(1), .MaxOutstanding(2)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(rr_req), .host_gnt_o(rr_gnt), .host_addr_i(addr), .host_we_i(we),
        .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rr_rvalid),
        .host_rdata_o(rr_rdata), .host_err_o(rr_herr),
        .device_req_o(rr_dreq), .device_addr_o(rr_daddr), .device_we_o(rr_dwe),
        .device_be_o(rr_dbe), .device_wdata_o(rr_dwdata), .device_rvalid_i(rr_drvalid),
        .device_rdata_i(rr_drdata), .device_err_i(rr_derr),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    // Round-robin instance's RAM answers every request exactly one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_drvalid <= '0;
        else        rr_drvalid <= rr_dreq;
    end
    assign rr_drdata = '{default: 32'h0BAD_F00D};
    assign rr_derr   = '0;

    typedef struct {
        int          host;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            for (int h = 0; h < NH; h++) begin
                if (rvalid[h]) begin
                    vec_cnt++;
                    if (sb.size() == 0) begin
                        err_cnt++;
                        $display("FAIL sb_unexpected host=%0d rvalid=1 with no response expected", h);
                    end else begin
                        e = sb.pop_front();
                        if (e.host != h || rdata[h] !== e.rdata || herr[h] !== e.err) begin
                            err_cnt++;
                            $display("FAIL sb_resp got host=%0d rdata=%h err=%b expected host=%0d rdata=%h err=%b",
                                     h, rdata[h], herr[h], e.host, e.rdata, e.err);
                        end else begin
                            $display("resp host=%0d rdata=%h err=%b", h, rdata[h], herr[h]);
                        end
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req = '1; rr_req = '1;
        addr[0] = 32'h100; addr[1] = 32'h104; addr[2] = 32'h30000;
        #1;
        for (int k = 0; k < 2; k++) begin
            vec_cnt++;
            if (gnt !== '0 || rr_gnt !== '0 || dreq !== '0 || rvalid !== '0 || herr !== '0) begin
                err_cnt++;
                $display("FAIL reset_ctrl gnt=%b rr_gnt=%b dreq=%b rvalid=%b err=%b required all 0",
                         gnt, rr_gnt, dreq, rvalid, herr);
            end
            vec_cnt++;
            if (daddr !== '0 || dwdata !== '0 || dbe !== '0 || rdata !== '0) begin
                err_cnt++;
                $display("FAIL reset_data daddr=%h dwdata=%h dbe=%h rdata=%h required 0",
                         daddr, dwdata, dbe, rdata);
            end
            @(posedge clk);
            #1;
        end
        req = '0; rr_req = '0;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_fixed_priority();
        req = 3'b101; addr[0] = 32'h100; addr[2] = 32'h100;
        @(negedge clk);
        vec_cnt++;
        if (gnt !== 3'b001 || dreq !== 2'b01 || daddr[0] !== 32'h100) begin
            err_cnt++;
            $display("FAIL fp_cycle0 gnt=%b dreq=%b addr=%h required 001/01/00000100", gnt, dreq, daddr[0]);
        end
        sb.push_back('{0, 32'h1111_0000, 1'b0});
        next_cycle();
        req = 3'b100; drvalid = 2'b01; drdata[0] = 32'h1111_0000;
        @(negedge clk);
        vec_cnt++;
        if (gnt !== 3'b100 || dreq !== 2'b01) begin
            err_cnt++;
            $display("FAIL fp_cycle1 gnt=%b dreq=%b required 100/01", gnt, dreq);
        end
        sb.push_back('{2, 32'h2222_0000, 1'b0});
        next_cycle();
        req = '0; drdata[0] = 32'h2222_0000;
        @(negedge clk);
        vec_cnt++;
        if (gnt !== '0) begin
            err_cnt++;
            $display("FAIL fp_idle gnt=%b required 000", gnt);
        end
        next_cycle();
        drvalid = '0;
    endtask

    task automatic test_decode_error();
        req = 3'b010; addr[1] = 32'h30000;
        @(negedge clk);
        vec_cnt++;
        if (gnt !== 3'b010 || dreq !== 2'b00 || rvalid !== 3'b000) begin
            err_cnt++;
            $display("FAIL derr_grant gnt=%b dreq=%b rvalid=%b required 010/00/000", gnt, dreq, rvalid);
        end
        sb.push_back('{1, 32'h0, 1'b1});
        next_cycle();
        req = '0;
        @(negedge clk);
        vec_cnt++;
        if (rvalid !== 3'b010 || herr !== 3'b010 || rdata[1] !== 32'h0) begin
            err_cnt++;
            $display("FAIL derr_resp rvalid=%b err=%b rdata=%h required 010/010/0", rvalid, herr, rdata[1]);
        end
        next_cycle();
        @(negedge clk);
        vec_cnt++;
        if (rvalid !== 3'b000) begin
            err_cnt++;
            $display("FAIL derr_once rvalid=%b required 000", rvalid);
        end
        next_cycle();
    endtask

    task automatic test_outstanding();
        logic [2:0]  t_req [7] = '{3'b001, 3'b110, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
        logic [2:0]  t_gnt [7] = '{3'b001, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
        logic        t_rv  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] t_rd  [7] = '{32'h0, 32'h0, 32'h0, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'h0};
        for (int h = 0; h < NH; h++) addr[h] = 32'h100 + 32'(4 * h);
        for (int c = 0; c < 7; c++) begin
            req = t_req[c]; drvalid[0] = t_rv[c]; drdata[0] = t_rd[c];
            @(negedge clk);
            vec_cnt++;
            if (gnt !== t_gnt[c] || dreq !== ((t_gnt[c] != 3'b000) ? 2'b01 : 2'b00)) begin
                err_cnt++;
                $display("FAIL mo_cycle%0d gnt=%b dreq=%b required gnt=%b", c, gnt, dreq, t_gnt[c]);
            end
            for (int h = 0; h < NH; h++)
                if (t_gnt[c][h]) sb.push_back('{h, 32'hB000_0000 + 32'(h), 1'b0});
            next_cycle();
        end
        drvalid = '0;
    endtask

    task automatic test_cross_device();
        logic [2:0] t_req [5] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010};
        logic [2:0] t_gnt [5] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010};
        logic [1:0] t_dq  [5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        addr[0] = 32'h100; addr[1] = 32'h20004;
        we[1] = 1'b1; be[1] = 4'hC; wdata[1] = 32'hCAFE_BABE;
        for (int c = 0; c < 5; c++) begin
            req = t_req[c];
            drvalid = (c == 3) ? 2'b01 : 2'b00;
            drdata[0] = 32'hC0C0_C0C0;
            @(negedge clk);
            vec_cnt++;
            if (gnt !== t_gnt[c] || dreq !== t_dq[c]) begin
                err_cnt++;
                $display("FAIL xdev_cycle%0d gnt=%b dreq=%b required %b/%b", c, gnt, dreq, t_gnt[c], t_dq[c]);
            end
            if (c == 0) sb.push_back('{0, 32'hC0C0_C0C0, 1'b0});
            if (c == 4) begin
                vec_cnt++;
                if (daddr[1] !== 32'h20004 || dwe !== 2'b10 || dbe[1] !== 4'hC ||
                    dwdata[1] !== 32'hCAFE_BABE || daddr[0] !== 32'h0) begin
                    err_cnt++;
                    $display("FAIL xdev_fwd addr=%h we=%b be=%h wdata=%h addr0=%h required 00020004/10/c/cafebabe/0",
                             daddr[1], dwe, dbe[1], dwdata[1], daddr[0]);
                end
                sb.push_back('{1, 32'h5A5A_5A5A, 1'b1});
            end
            next_cycle();
        end
        req = '0; we = '0; drvalid = 2'b10; drdata[1] = 32'h5A5A_5A5A; derr = 2'b10;
        next_cycle();
        drvalid = '0; derr = '0;
    endtask

    task automatic test_reset_midflight();
        addr[0] = 32'h100; addr[1] = 32'h100; addr[2] = 32'h100;
        req = 3'b001;
        @(negedge clk);
        next_cycle();
        req = 3'b100;
        @(negedge clk);
        vec_cnt++;
        if (gnt !== 3'b100) begin
            err_cnt++;
            $display("FAIL rst_fill gnt=%b required 100", gnt);
        end
        next_cycle();
        req = 3'b010; drvalid = 2'b01; drdata[0] = 32'hDEAD_BEEF;
        #1 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (gnt !== '0 || dreq !== '0 || rvalid !== '0 || daddr !== '0 || rdata !== '0) begin
            err_cnt++;
            $display("FAIL rst_async gnt=%b dreq=%b rvalid=%b daddr=%h rdata=%h required 0",
                     gnt, dreq, rvalid, daddr, rdata);
        end
        @(posedge clk);
        #1;
        req = '0; rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (rvalid !== '0 || gnt !== '0) begin
            err_cnt++;
            $display("FAIL rst_late_rvalid rvalid=%b gnt=%b required 000/000", rvalid, gnt);
        end
        next_cycle();
        drvalid = '0;
        sb.delete();
        req = 3'b010; addr[1] = 32'h104;
        @(negedge clk);
        vec_cnt++;
        if (gnt !== 3'b010 || dreq !== 2'b01) begin
            err_cnt++;
            $display("FAIL rst_recover gnt=%b dreq=%b required 010/01", gnt, dreq);
        end
        sb.push_back('{1, 32'h7777_7777, 1'b0});
        next_cycle();
        req = '0; drvalid = 2'b01; drdata[0] = 32'h7777_7777;
        next_cycle();
        drvalid = '0;
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 0, 1, 2};
        addr[0] = 32'h100; addr[1] = 32'h100; addr[2] = 32'h100;
        rr_req = 3'b111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vec_cnt++;
            if (rr_gnt !== 3'(1 << order[c]) || rr_dreq !== 2'b01) begin
                err_cnt++;
                $display("FAIL rr_grant%0d gnt=%b dreq=%b required host %0d", c, rr_gnt, rr_dreq, order[c]);
            end else begin
                $display("rr grant host=%0d", order[c]);
            end
            if (c > 0) begin
                vec_cnt++;
                if (rr_rvalid !== 3'(1 << order[c-1])) begin
                    err_cnt++;
                    $display("FAIL rr_resp%0d rvalid=%b required host %0d", c, rr_rvalid, order[c-1]);
                end
            end
            next_cycle();
        end
        rr_req = '0;
        @(negedge clk);
        vec_cnt++;
        if (rr_rvalid !== 3'b100 || rr_gnt !== 3'b000 || rr_rdata[2] !== 32'h0BAD_F00D) begin
            err_cnt++;
            $display("FAIL rr_drain rvalid=%b gnt=%b rdata=%h required 100/000/0badf00d",
                     rr_rvalid, rr_gnt, rr_rdata[2]);
        end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0; rr_req = '0; we = '0; be = '{default: 4'hF};
        addr = '0; wdata = '0;
        drvalid = '0; drdata = '0; derr = '0;
        cfg_base[0] = 32'h0000_0000; cfg_mask[0] = 32'hFFFF_0000;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_0000;

        test_reset();
        test_fixed_priority();
        test_decode_error();
        test_outstanding();
        test_cross_device();
        test_round_robin();
        test_reset_midflight();

        vec_cnt++;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL sb_drained %0d responses outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
